// File: rtl/clk_period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous clock in clockin cycles,
// with stall detection and a wrapping edge counter.
module clk_period_meter #(
    parameter int unsigned WIDTH   = 26,
    parameter int unsigned TIMEOUT = 20_000_000
) (
    input  logic             clockin,
    input  logic             resetn,
    input  logic             sigin,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic [7:0]       edge_count
);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        STALL
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             edge_p;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic             period_valid_nxt;
    logic             stalled_nxt;

    // s3 resets low, so a sigin already high at reset release yields one edge pulse
    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sigin;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_p = s2 & ~s3;

    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            state        <= WAIT_FIRST;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period       <= period_nxt;
            period_valid <= period_valid_nxt;
            stalled      <= stalled_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        period_nxt       = period;
        period_valid_nxt = 1'b0;
        stalled_nxt      = stalled;
        case (state)
            WAIT_FIRST: begin
                if (edge_p) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                // An edge landing exactly on the timeout still counts as a valid measurement
                if (edge_p) begin
                    period_nxt       = cnt;
                    period_valid_nxt = 1'b1;
                    cnt_nxt          = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt   = STALL;
                    stalled_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STALL: begin
                if (edge_p) begin
                    cnt_nxt     = CNT_ONE;
                    stalled_nxt = 1'b0;
                    state_nxt   = MEASURE;
                end
            end
            default: state_nxt = WAIT_FIRST;
        endcase
    end

    always_ff @(posedge clockin or negedge resetn) begin
        if (!resetn) begin
            edge_count <= '0;
        end else if (edge_p) begin
            edge_count <= edge_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed self-checking bench for clk_period_meter with TIMEOUT overridden to 20.
module tb_clk_period_meter;

    localparam int unsigned W  = 26;
    localparam int unsigned NV = 11;

    logic          clockin = 1'b0;
    logic          resetn;
    logic          sigin;
    logic [W-1:0]  period;
    logic          period_valid;
    logic          stalled;
    logic [7:0]    edge_count;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    clk_period_meter #(.WIDTH(W), .TIMEOUT(20)) dut (
        .clockin      (clockin),
        .resetn       (resetn),
        .sigin        (sigin),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .edge_count   (edge_count)
    );

    always #5 clockin = ~clockin;

    typedef struct {
        int unsigned p;           // rising-to-rising spacing driven by this vector
        int unsigned exp_period;  // interval ending at this vector's edge
        logic        exp_pv;
        int unsigned exp_ec;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clockin);
        #1;
    endtask

    // Raise sigin and step to the cycle where the FSM's reaction is visible
    task automatic rise_and_sync();
        sigin = 1'b1;
        repeat (3) tick();
        sigin = 1'b0;
    endtask

    task automatic check_outs(input string tag, input longint unsigned p, input logic pv,
                              input logic st, input longint unsigned ec);
        check({tag, "_period"}, period, p);
        check({tag, "_valid"}, period_valid, pv);
        check({tag, "_stalled"}, stalled, st);
        check({tag, "_edge_count"}, edge_count, ec);
    endtask

    logic         prev_pv = 1'b0;
    logic [W-1:0] prev_period = '0;

    always @(negedge clockin) begin
        if (resetn === 1'b1) begin
            check("pv_adjacent", period_valid & prev_pv, 0);
            if (!period_valid) check("period_hold", period, prev_period);
        end
        prev_pv     = period_valid;
        prev_period = period;
    end

    initial begin
        vecs[0]  = '{10, 0,  1'b0, 1};
        vecs[1]  = '{10, 10, 1'b1, 2};
        vecs[2]  = '{10, 10, 1'b1, 3};
        vecs[3]  = '{7,  10, 1'b1, 4};
        vecs[4]  = '{6,  7,  1'b1, 5};
        vecs[5]  = '{6,  6,  1'b1, 6};
        vecs[6]  = '{20, 6,  1'b1, 7};
        vecs[7]  = '{20, 20, 1'b1, 8};
        vecs[8]  = '{3,  20, 1'b1, 9};
        vecs[9]  = '{3,  3,  1'b1, 10};
        vecs[10] = '{10, 3,  1'b1, 11};

        resetn = 1'b0;
        sigin  = 1'b0;
        #1;
        check_outs("reset", 0, 1'b0, 1'b0, 0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < NV; i++) begin
            sigin = 1'b1;
            for (int unsigned k = 1; k <= vecs[i].p; k++) begin
                tick();
                if (k == 3)
                    check_outs($sformatf("vec%0d", i), vecs[i].exp_period, vecs[i].exp_pv, 1'b0, vecs[i].exp_ec);
                if (k == vecs[i].p / 2) sigin = 1'b0;
            end
        end

        // Last measured edge, then let sigin sit idle until the stall fires
        rise_and_sync();
        check_outs("pre_stall", 10, 1'b1, 1'b0, 12);
        repeat (19) tick();
        check("stall_early", stalled, 0);
        tick();
        check("stall_set", stalled, 1);
        check("stall_no_valid", period_valid, 0);
        repeat (5) tick();
        check("stall_hold", stalled, 1);
        rise_and_sync();
        check_outs("stall_exit", 10, 1'b0, 1'b0, 13);
        repeat (5) tick();
        rise_and_sync();
        check_outs("post_stall", 8, 1'b1, 1'b0, 14);

        // Reset mid-interval with cnt at 7; sigin held high across release
        repeat (6) tick();
        resetn = 1'b0;
        #1;
        check_outs("async_reset", 0, 1'b0, 1'b0, 0);
        sigin = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        check_outs("rearm", 0, 1'b0, 1'b0, 1);
        sigin = 1'b0;
        repeat (3) tick();
        rise_and_sync();
        check_outs("after_rearm", 6, 1'b1, 1'b0, 2);

        // 257 edges at spacing 4 from a fresh reset
        resetn = 1'b0;
        sigin  = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        repeat (2) tick();
        for (int n = 0; n < 257; n++) begin
            sigin = 1'b1;
            repeat (2) tick();
            sigin = 1'b0;
            repeat (2) tick();
        end
        check("wrap_edge_count", edge_count, 1);
        check("wrap_period", period, 4);
        check("wrap_stalled", stalled, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
